mem_dump_streamer: RTL and testbench

//  Reader side of the data memory that the core writes through data_mem.

---
 rtl/mem_dump_streamer.sv | 97 +++++++++
 tb/tb_mem_dump_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_streamer.sv
// Post-halt dump engine: takes the data_mem read port and streams COUNT bytes
// from BASE_ADDR out over a valid/ready byte interface, one beat per two cycles.
module mem_dump_streamer #(
  parameter int A         = 8,
  parameter int BASE_ADDR = 0,
  parameter int COUNT     = 256
) (
  input  logic         clk,
  input  logic         start,
  input  logic         halt,
  output logic         mem_owner,
  output logic [A-1:0] mem_addr,
  output logic         mem_read,
  input  logic [7:0]   mem_data,
  output logic [7:0]   dout_data,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         done
);

  localparam int IW = $clog2(COUNT) + 1;

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          halt_q, halt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          accept;

  assign accept = valid_q & dout_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    halt_d  = halt;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (halt_q) state_d = READ;
      READ: begin
        data_d  = mem_data;
        valid_d = 1'b1;
        last_d  = (idx_q == IW'(COUNT - 1));
        state_d = HOLD;
      end
      HOLD: begin
        // Valid drops on every accept, so beats never go back-to-back.
        if (accept) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = READ;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q <= IDLE;
      idx_q   <= '0;
      halt_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      halt_q  <= halt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Address wraps modulo 2**A; parked at zero whenever the core owns the port.
  assign mem_owner  = (state_q == READ) || (state_q == HOLD);
  assign mem_addr   = mem_owner ? (A'(BASE_ADDR) + A'(idx_q)) : '0;
  assign mem_read   = (state_q == READ);
  assign busy       = mem_owner;
  assign done       = (state_q == DONE);
  assign dout_data  = data_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Scoreboard bench for mem_dump_streamer: two instances (BASE 0 and BASE 254,
// both COUNT 4) sharing one memory image and one reset.
module tb_mem_dump_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       start, halt0, halt1, rdy0, rdy1;
  logic       own0, rd0, v0, l0, busy0, done0;
  logic       own1, rd1, v1, l1, busy1, done1;
  logic [7:0] a0, a1, md0, md1, d0, d1;
  logic [7:0] mem [256];

  assign md0 = mem[a0];
  assign md1 = mem[a1];

  mem_dump_streamer #(.A(8), .BASE_ADDR(0), .COUNT(4)) dut0 (
    .clk(clk), .start(start), .halt(halt0), .mem_owner(own0), .mem_addr(a0),
    .mem_read(rd0), .mem_data(md0), .dout_data(d0), .dout_valid(v0),
    .dout_ready(rdy0), .dout_last(l0), .busy(busy0), .done(done0));

  mem_dump_streamer #(.A(8), .BASE_ADDR(254), .COUNT(4)) dut1 (
    .clk(clk), .start(start), .halt(halt1), .mem_owner(own1), .mem_addr(a1),
    .mem_read(rd1), .mem_data(md1), .dout_data(d1), .dout_valid(v1),
    .dout_ready(rdy1), .dout_last(l1), .busy(busy1), .done(done1));

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  beat_t      sb0[$], sb1[$];
  logic [7:0] addr1[$];
  beat_t      e0, e1;
  int checks = 0, errors = 0;
  int cyc = 0, acc0 = 0, acc1 = 0, last_acc0 = -1;
  bit gap_chk = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 && rdy0) begin
      acc0++;
      if (gap_chk && last_acc0 >= 0) chk("gap0", cyc - last_acc0, 2);
      last_acc0 = cyc;
      if (sb0.size() == 0) chk("sb0_extra_beat", 1, 0);
      else begin
        e0 = sb0.pop_front();
        chk("beat0_data", d0, e0.d);
        chk("beat0_last", l0, e0.l);
      end
    end
    if (v1 && rdy1) begin
      acc1++;
      if (sb1.size() == 0) chk("sb1_extra_beat", 1, 0);
      else begin
        e1 = sb1.pop_front();
        chk("beat1_data", d1, e1.d);
        chk("beat1_last", l1, e1.l);
      end
    end
    if (rd0) chk("rd0_owned", own0, 1);
    if (rd1) begin
      chk("rd1_owned", own1, 1);
      if (addr1.size() == 0) chk("addr1_extra", 1, 0);
      else chk("addr1", a1, addr1.pop_front());
    end
  end

  task automatic push_dump(int which, int base, int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = mem[(base + i) % 256];
      b.l = (i == n - 1);
      if (which == 0) sb0.push_back(b);
      else begin
        sb1.push_back(b);
        addr1.push_back(8'((base + i) % 256));
      end
    end
  endtask

  task automatic wait_acc0(int n);
    int t = 0;
    while (acc0 < n && t < 200) begin @(posedge clk); #1; t++; end
    chk("acc0_wait", acc0 >= n, 1);
  endtask

  task automatic wait_done(int which);
    int t = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk(which == 0 ? "done0_wait" : "done1_wait", (which == 0) ? done0 : done1, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    acc0 = 0;
    acc1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    start = 1'b1; halt0 = 1'b0; halt1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5a);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[254] = 8'ha1; mem[255] = 8'ha2;
    @(posedge clk); #1;
    chk("rst_owner", own0, 0);
    chk("rst_addr", a0, 0);
    chk("rst_read", rd0, 0);
    chk("rst_data", d0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_last", l0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    @(posedge clk); #1 start = 1'b0;

    // Idle with halt low: no ownership, no beats.
    rdy0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_owner", own0, 0);
      chk("idle_valid", v0, 0);
    end

    // Basic dump, ready tied high, with latency and spacing checks.
    push_dump(0, 0, 4);
    gap_chk = 1; last_acc0 = -1;
    @(posedge clk); #1 halt0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 chk("lat_n1_valid", v0, 0);
    @(posedge clk); #1 chk("lat_n2_valid", v0, 1);
    wait_done(0);
    gap_chk = 0;
    chk("t1_beats", acc0, 4);
    chk("t1_sb_empty", sb0.size(), 0);
    chk("t1_busy", busy0, 0);
    chk("t1_owner", own0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_halt_ignored", done0, 1);
    chk("done_valid", v0, 0);
    halt0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("done_sticky", done0, 1);
    pulse_start();
    chk("start_clears_done", done0, 0);

    // Backpressure on beat 2.
    push_dump(0, 0, 4);
    halt0 = 1'b1;
    wait_acc0(1);
    rdy0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", v0, 1);
      chk("stall_data", d0, 8'h22);
      chk("stall_last", l0, 0);
    end
    rdy0 = 1'b1;
    wait_done(0);
    chk("t2_beats", acc0, 4);
    chk("t2_sb_empty", sb0.size(), 0);
    halt0 = 1'b0;
    pulse_start();

    // Halt dropped after first beat: dump still completes.
    push_dump(0, 0, 4);
    halt0 = 1'b1;
    wait_acc0(1);
    halt0 = 1'b0;
    wait_done(0);
    chk("t5_beats", acc0, 4);
    chk("t5_sb_empty", sb0.size(), 0);
    pulse_start();

    // Reset while holding beat 3 abandons the dump.
    push_dump(0, 0, 4);
    halt0 = 1'b1;
    wait_acc0(2);
    rdy0 = 1'b0;
    @(posedge clk); #1;
    chk("t4_hold_valid", v0, 1);
    chk("t4_hold_data", d0, 8'h33);
    start = 1'b1; halt0 = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    chk("t4_valid", v0, 0);
    chk("t4_owner", own0, 0);
    chk("t4_busy", busy0, 0);
    chk("t4_done", done0, 0);
    sb0.delete();
    repeat (3) @(posedge clk);
    #1 chk("t4_stays_idle", {own0, v0, done0}, 0);
    acc0 = 0;

    // Wrapping dump from 254.
    rdy1 = 1'b1;
    push_dump(1, 254, 4);
    halt1 = 1'b1;
    wait_done(1);
    chk("t3_beats", acc1, 4);
    chk("t3_sb_empty", sb1.size(), 0);
    chk("t3_addr_empty", addr1.size(), 0);
    chk("t3_owner", own1, 0);
    chk("t3_busy", busy1, 0);
    halt1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
